fpcvt_seq: RTL and testbench

//   Parametrised, sequential two's-complement to compact floating-point converter: S + EXP_W exponent + MAN_W significand, value = F * 2^E.

---
 rtl/fpcvt_seq.sv | 174 +++++++++++++++++
 tb/tb_fpcvt_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fpcvt_seq.sv
// Sequential two's-complement to compact floating-point converter.
// Result is sign + EXP_W exponent + MAN_W significand (no hidden bit),
// value = F * 2^E. The magnitude is normalised one left shift per clock,
// then optionally rounded half-up with saturation at the top exponent.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a sample; captures sign, magnitude and round mode
//   NORM  | shifting magnitude left until MSB set or exponent reaches 0
//   ROUND | rounding / renormalising / saturating, registering outputs
//   DONE  | result presented, waiting for out_ready
module fpcvt_seq #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_rnd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_s,
    output logic [EXP_W-1:0]  out_e,
    output logic [MAN_W-1:0]  out_f,
    output logic              out_sat
);

    localparam int MW   = IN_W - 1;
    localparam int EMAX = IN_W - 1 - MAN_W;
    localparam logic [EXP_W-1:0] EMAX_E   = EXP_W'(EMAX);
    localparam logic [MAN_W-1:0] F_RENORM = {1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [MW-1:0]      m_q, m_n;
    logic [EXP_W-1:0]   e_q, e_n;
    logic               s_q, s_n;
    logic               rnd_q, rnd_n;
    logic               sat_q, sat_n;
    logic               out_valid_n, out_s_n, out_sat_n;
    logic [EXP_W-1:0]   out_e_n;
    logic [MAN_W-1:0]   out_f_n;

    logic               min_neg;
    logic [MW-1:0]      neg_mag;
    logic [MW-1:0]      m_cap;
    logic [MAN_W-1:0]   f_base;
    logic               r_bit;
    logic               do_inc;
    logic [MAN_W:0]     f_sum;

    // Magnitude of the incoming sample; the most-negative code has no
    // positive twin in IN_W-1 bits, so it clamps to all ones.
    always_comb begin
        min_neg = in_data[IN_W-1] & ~(|in_data[IN_W-2:0]);
        neg_mag = ~in_data[MW-1:0] + MW'(1);
        if (min_neg)
            m_cap = '1;
        else if (in_data[IN_W-1])
            m_cap = neg_mag;
        else
            m_cap = in_data[MW-1:0];
    end

    // Rounding arithmetic on the normalised magnitude; E==0 results are exact.
    always_comb begin
        f_base = m_q[MW-1 -: MAN_W];
        r_bit  = m_q[MW-1-MAN_W];
        do_inc = rnd_q & r_bit & (e_q != '0);
        f_sum  = {1'b0, f_base} + {{MAN_W{1'b0}}, do_inc};
    end

    // Next-state and datapath updates.
    always_comb begin
        state_n     = state;
        m_n         = m_q;
        e_n         = e_q;
        s_n         = s_q;
        rnd_n       = rnd_q;
        sat_n       = sat_q;
        out_valid_n = out_valid;
        out_s_n     = out_s;
        out_e_n     = out_e;
        out_f_n     = out_f;
        out_sat_n   = out_sat;
        in_ready    = (state == IDLE) && !rst;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    s_n     = in_data[IN_W-1];
                    rnd_n   = in_rnd;
                    m_n     = m_cap;
                    sat_n   = min_neg;
                    e_n     = EMAX_E;
                    state_n = NORM;
                end
            end
            NORM: begin
                if (m_q[MW-1] || (e_q == '0)) begin
                    state_n = ROUND;
                end else begin
                    m_n = {m_q[MW-2:0], 1'b0};
                    e_n = e_q - EXP_W'(1);
                end
            end
            ROUND: begin
                out_s_n   = s_q;
                out_sat_n = sat_q;
                if (f_sum[MAN_W]) begin
                    if (e_q != EMAX_E) begin
                        out_f_n = F_RENORM;
                        out_e_n = e_q + EXP_W'(1);
                    end else begin
                        out_f_n   = '1;
                        out_e_n   = EMAX_E;
                        out_sat_n = 1'b1;
                    end
                end else begin
                    out_f_n = f_sum[MAN_W-1:0];
                    out_e_n = e_q;
                end
                out_valid_n = 1'b1;
                state_n     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            m_q       <= '0;
            e_q       <= '0;
            s_q       <= 1'b0;
            rnd_q     <= 1'b0;
            sat_q     <= 1'b0;
            out_valid <= 1'b0;
            out_s     <= 1'b0;
            out_e     <= '0;
            out_f     <= '0;
            out_sat   <= 1'b0;
        end else begin
            state     <= state_n;
            m_q       <= m_n;
            e_q       <= e_n;
            s_q       <= s_n;
            rnd_q     <= rnd_n;
            sat_q     <= sat_n;
            out_valid <= out_valid_n;
            out_s     <= out_s_n;
            out_e     <= out_e_n;
            out_f     <= out_f_n;
            out_sat   <= out_sat_n;
        end
    end

endmodule

// File: tb/tb_fpcvt_seq.sv
// Directed bench for fpcvt_seq at default parameters (12-bit -> 1/3/4).
module tb_fpcvt_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        in_rnd;
    logic        out_valid;
    logic        out_ready;
    logic        out_s;
    logic [2:0]  out_e;
    logic [3:0]  out_f;
    logic        out_sat;

    int errors = 0;
    int checks = 0;

    fpcvt_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_rnd    (in_rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_e     (out_e),
        .out_f     (out_f),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a sample and clock it in once in_ready is seen.
    task automatic send(input logic [11:0] d, input logic r);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_rnd   = r;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 12'($urandom);
        in_rnd   = 1'($urandom);
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic chk_out(input string tag, input logic s, input logic [2:0] e,
                           input logic [3:0] f, input logic sat);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_s"},     32'(out_s),     32'(s));
        chk({tag, "_e"},     32'(out_e),     32'(e));
        chk({tag, "_f"},     32'(out_f),     32'(f));
        chk({tag, "_sat"},   32'(out_sat),   32'(sat));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_drop"},  32'(out_valid), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready),  32'd1);
    endtask

    task automatic conv(input string tag, input logic [11:0] d, input logic r, input int lat,
                        input logic s, input logic [2:0] e, input logic [3:0] f, input logic sat);
        send(d, r);
        wait_result(tag, lat);
        chk_out(tag, s, e, f, sat);
        release_out(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rnd    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_ready",   32'(in_ready),  32'd0);
        chk("rst_outs",    32'({out_s, out_e, out_f, out_sat}), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        tick();

        conv("c422",   12'd422,  1'b1, 4, 1'b0, 3'd5, 4'b1101, 1'b0);
        conv("c125t",  12'd125,  1'b0, 6, 1'b0, 3'd3, 4'b1111, 1'b0);
        conv("c125r",  12'd125,  1'b1, 6, 1'b0, 3'd4, 4'b1000, 1'b0);
        conv("cm422",  12'hE5A,  1'b1, 4, 1'b1, 3'd5, 4'b1101, 1'b0);
        conv("c9",     12'd9,    1'b1, 9, 1'b0, 3'd0, 4'b1001, 1'b0);
        conv("c0",     12'd0,    1'b1, 9, 1'b0, 3'd0, 4'b0000, 1'b0);
        conv("c800",   12'h800,  1'b0, 2, 1'b1, 3'd7, 4'b1111, 1'b1);
        conv("c2047r", 12'd2047, 1'b1, 2, 1'b0, 3'd7, 4'b1111, 1'b1);
        conv("c2047t", 12'd2047, 1'b0, 2, 1'b0, 3'd7, 4'b1111, 1'b0);
        // 100 = 1100100b: 4 shifts, E=3, F=1100, round bit 1 -> 1101.
        conv("c100r",  12'd100,  1'b1, 6, 1'b0, 3'd3, 4'b1101, 1'b0);

        // Backpressure, with a competing input held valid while busy.
        send(12'd422, 1'b1);
        in_valid = 1'b1;
        in_data  = 12'd125;
        in_rnd   = 1'b1;
        wait_result("bp", 4);
        for (int i = 0; i < 5; i++) begin
            chk_out("bp_hold", 1'b0, 3'd5, 4'b1101, 1'b0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_drop",  32'(out_valid), 32'd0);
        chk("bp_ready", 32'(in_ready),  32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 12'hABC;
        chk("b2b_accepted", 32'(in_ready), 32'd0);
        wait_result("b2b", 6);
        chk_out("b2b", 1'b0, 3'd4, 4'b1000, 1'b0);
        release_out("b2b");

        // Reset in the middle of normalisation, with stale nonzero outputs held.
        send(12'd9, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_outs",  32'({out_s, out_e, out_f, out_sat}), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_rel_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("mid_rst_no_result", 32'(out_valid), 32'd0);
        end
        conv("after_rst", 12'hE5A, 1'b0, 4, 1'b1, 3'd5, 4'b1101, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
